ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set LEDs,
//  0xFF reset) to the keyboard using the inhibit / request-to-send sequence.
//  Sits beside the PS/2 receiver on the same PS2_CLK/PS2_DATA pins.
//  Lines are open-collector: this block only ever pulls low via *_OE.
//  BUSY gates the receiver so it ignores bits while a command is sent.
// PARAMETERS
//  INHIBIT_TICKS  240    clk_en ticks CLK is held low (>=100us; 120us at 2MHz)
//  TIMEOUT_TICKS  40000  clk_en ticks without a device CLK fall before abort (20ms)
//  FILTER_LEN     8      clk_en samples in the PS2_CLK glitch filter
// PORTS
//  clk         in   1  system clock
//  nRESET      in   1  reset, synchronous, active-low
//  clk_en      in   1  sample/tick enable; all timing and filtering advance on it
//  PS2_CLK     in   1  PS/2 clock line as read at the pin
//  PS2_DATA    in   1  PS/2 data line as read at the pin
//  TX_DATA     in   8  command byte, captured on an accepted TX_START
//  TX_START    in   1  request; accepted on any clk cycle when state=IDLE
//  PS2_CLK_OE  out  1  1 = pull PS2_CLK low; 0 = release (pulled up)
//  PS2_DATA_OE out  1  1 = pull PS2_DATA low; 0 = release
//  BUSY        out  1  high from the clk after acceptance until return to IDLE
//  DONE        out  1  one-clk pulse: byte sent and device ACK seen
//  ERROR       out  1  one-clk pulse: timeout or missing ACK
// BEHAVIOUR
//  Reset: state IDLE, both OE=0, BUSY=0, DONE=0, ERROR=0, filter=all ones,
//   filtered clock level=1. Reset mid-transfer releases both lines immediately.
//  Filter: shift PS2_CLK in on clk_en; level->0 when all FILTER_LEN bits are 0,
//   level->1 when all are 1, else hold. FALL = level 1->0 transition (one tick).
//  Frame: shift reg = {stop 1, odd parity ^TX_DATA inverted, TX_DATA[7:0]}, LSB first.
//  States (transitions on clk_en ticks, except IDLE acceptance):
//   IDLE: OE=0. TX_START=1 -> latch TX_DATA, clear counters, ->INHIBIT; BUSY=1 next clk.
//   INHIBIT: CLK_OE=1, DATA_OE=0; after INHIBIT_TICKS ticks -> RTS.
//   RTS: DATA_OE=1 for 1 tick with CLK_OE=1, then CLK_OE=0 -> SEND (start bit=0 on line).
//   SEND: on each FALL, bit_cnt++ and drive next frame bit (DATA_OE = ~bit); falls
//    1..8 put D0..D7, fall 9 parity, fall 10 stop (DATA_OE=0) -> ACK.
//   ACK: on next FALL sample PS2_DATA: 0 -> WAIT_IDLE; 1 -> ERROR pulse, ->IDLE.
//   WAIT_IDLE: filtered level=1 and PS2_DATA=1 -> DONE pulse, ->IDLE.
//  Timeout: tick counter clears on every FALL and on state entry; in RTS/SEND/ACK/
//   WAIT_IDLE reaching TIMEOUT_TICKS -> both OE=0, ERROR pulse, ->IDLE.
//  DONE/ERROR never assert together; BUSY falls in the same clk as either pulse.
//  TX_START while BUSY=1 is ignored (not queued). Simultaneous FALL and timeout:
//   FALL wins. DATA_OE changes only on FALL ticks during SEND.
//  Latency: CLK_OE rises 1 clk after acceptance; CLK held low exactly
//   INHIBIT_TICKS+1 ticks (inhibit plus RTS overlap tick).
// TESTING
//  1 Reset, idle lines -> OE=0, BUSY=0; pulse nRESET during SEND -> OE=0 next clk.
//  2 TX 0xF4, device model clocks 11 falls, ACKs -> bits 0,0,0,1,0,1,1,1,1, parity 0,
//    stop released; DONE one pulse; BUSY low after.
//  3 TX 0xED -> parity bit 1 (six ones); TX 0xFF -> parity 1; TX 0x00 -> parity 1.
//  4 Device holds PS2_DATA high at ACK fall -> ERROR pulse, no DONE, IDLE.
//  5 Device never clocks after RTS -> ERROR after TIMEOUT_TICKS ticks, OE=0.
//  6 1-2 tick glitches on PS2_CLK during SEND -> no extra bits; TX_START during
//    BUSY ignored; CLK_OE low-time = INHIBIT_TICKS+1 ticks measured.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a controller and the PS/2 host transmitter
//  TX_DATA   controller -> tx  command byte, captured on an accepted TX_START
//  TX_START  controller -> tx  send request, honoured only while idle
//  BUSY      tx -> controller  transfer in progress (also gates the PS/2 receiver)
//  DONE      tx -> controller  one-clk pulse, byte sent and device ACK seen
//  ERROR     tx -> controller  one-clk pulse, timeout or missing ACK
interface ps2_host_tx_if;
   logic [7:0] TX_DATA;
   logic       TX_START;
   logic       BUSY;
   logic       DONE;
   logic       ERROR;
   modport master (output TX_DATA, TX_START, input BUSY, DONE, ERROR);
   modport slave  (input TX_DATA, TX_START, output BUSY, DONE, ERROR);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, frame, ACK)
//  clk          system clock
//  nRESET       synchronous active-low reset
//  clk_en       tick enable; all timing and filtering advance on it
//  PS2_CLK      PS/2 clock line as read at the pin
//  PS2_DATA     PS/2 data line as read at the pin
//  PS2_CLK_OE   1 = pull PS2_CLK low (open collector)
//  PS2_DATA_OE  1 = pull PS2_DATA low (open collector)
//  host         command handshake (TX_DATA/TX_START in, BUSY/DONE/ERROR out)
module ps2_host_tx #(
   parameter int INHIBIT_TICKS = 240,
   parameter int TIMEOUT_TICKS = 40000,
   parameter int FILTER_LEN    = 8
) (
   input  logic         clk,
   input  logic         nRESET,
   input  logic         clk_en,
   input  logic         PS2_CLK,
   input  logic         PS2_DATA,
   output logic         PS2_CLK_OE,
   output logic         PS2_DATA_OE,
   ps2_host_tx_if.slave host
);
   localparam int CW = $clog2(INHIBIT_TICKS > TIMEOUT_TICKS ? INHIBIT_TICKS : TIMEOUT_TICKS) + 1;
   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
   state_t                state;
   logic [FILTER_LEN-1:0] filt;
   logic [FILTER_LEN-1:0] filt_n;
   logic                  level;
   logic                  fall;
   logic                  timeout;
   logic [CW-1:0]         cnt;
   logic [3:0]            bit_cnt;
   logic [9:0]            shift;
   assign filt_n  = {filt[FILTER_LEN-2:0], PS2_CLK};
   // a fall is the filtered level dropping, seen on the tick the last zero arrives
   assign fall    = clk_en && level && (filt_n == '0);
   assign timeout = (cnt == CW'(TIMEOUT_TICKS - 1));
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         state       <= IDLE;
         PS2_CLK_OE  <= 1'b0;
         PS2_DATA_OE <= 1'b0;
         host.BUSY   <= 1'b0;
         host.DONE   <= 1'b0;
         host.ERROR  <= 1'b0;
         filt        <= '1;
         level       <= 1'b1;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
      end else begin
         host.DONE  <= 1'b0;
         host.ERROR <= 1'b0;
         if (clk_en) begin
            filt  <= filt_n;
            level <= (filt_n == '0) ? 1'b0 : (&filt_n) ? 1'b1 : level;
         end
         case (state)
            IDLE: if (host.TX_START) begin
               // frame bits leave LSB first: D0..D7, odd parity, stop
               shift      <= {1'b1, ~^host.TX_DATA, host.TX_DATA};
               cnt        <= '0;
               bit_cnt    <= '0;
               PS2_CLK_OE <= 1'b1;
               host.BUSY  <= 1'b1;
               state      <= INHIBIT;
            end
            INHIBIT: if (clk_en) begin
               if (cnt == CW'(INHIBIT_TICKS - 1)) begin
                  cnt         <= '0;
                  PS2_DATA_OE <= 1'b1;
                  state       <= RTS;
               end else
                  cnt <= cnt + 1'b1;
            end
            // start bit already on the line; releasing CLK hands clocking to the device
            RTS: if (clk_en) begin
               PS2_CLK_OE <= 1'b0;
               cnt        <= '0;
               state      <= SEND;
            end
            SEND, ACK, WAIT_IDLE: if (clk_en) begin
               if (state == WAIT_IDLE && level && PS2_DATA) begin
                  host.DONE <= 1'b1;
                  host.BUSY <= 1'b0;
                  state     <= IDLE;
               end else if (fall) begin
                  cnt <= '0;
                  if (state == SEND) begin
                     bit_cnt     <= bit_cnt + 4'd1;
                     PS2_DATA_OE <= ~shift[0];
                     shift       <= shift >> 1;
                     if (bit_cnt == 4'd9)
                        state <= ACK;
                  end else if (state == ACK) begin
                     if (PS2_DATA) begin
                        host.ERROR <= 1'b1;
                        host.BUSY  <= 1'b0;
                        state      <= IDLE;
                     end else
                        state <= WAIT_IDLE;
                  end
               end else if (timeout) begin
                  PS2_CLK_OE  <= 1'b0;
                  PS2_DATA_OE <= 1'b0;
                  host.ERROR  <= 1'b1;
                  host.BUSY   <= 1'b0;
                  state       <= IDLE;
               end else
                  cnt <= cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model driving ps2_host_tx, checked against frame rules
module tb_ps2_host_tx;
   localparam int IT = 12;
   localparam int TO = 300;
   localparam int FL = 4;
   logic clk, nRESET, clk_en, dev_clk, dev_data, clk_oe, data_oe, ps2_clk, ps2_data;
   int   ticks, done_cnt, err_cnt, bad_cnt, n_checks, n_pass;
   ps2_host_tx_if host();
   ps2_host_tx #(.INHIBIT_TICKS(IT), .TIMEOUT_TICKS(TO), .FILTER_LEN(FL)) dut (
      .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .PS2_CLK_OE(clk_oe), .PS2_DATA_OE(data_oe), .host(host));
   // open-collector wired lines: either side may pull low
   assign ps2_clk  = ~clk_oe & dev_clk;
   assign ps2_data = ~data_oe & dev_data;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      clk_en = 1'b0;
      forever begin
         @(negedge clk);
         clk_en = ($urandom_range(0, 3) != 0);
      end
   end
   always @(posedge clk) if (clk_en) ticks <= ticks + 1;
   initial begin
      forever begin
         @(negedge clk);
         if (host.DONE) done_cnt++;
         if (host.ERROR) err_cnt++;
         if (((host.DONE || host.ERROR) && host.BUSY) || (host.DONE && host.ERROR)) bad_cnt++;
      end
   end
   // expected 11 line values sampled before each device fall: start, D0..D7, odd parity, stop
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
   endfunction
   task automatic wait_ticks(input int n);
      int t;
      t = ticks;
      while (ticks < t + n) @(negedge clk);
   endtask
   task automatic start_tx(input logic [7:0] d, output int t_r, output logic [1:0] acc);
      host.TX_DATA  = d;
      host.TX_START = 1'b1;
      @(negedge clk);
      host.TX_START = 1'b0;
      t_r = ticks;
      acc = {clk_oe, host.BUSY};
   endtask
   task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                            output logic [10:0] got, output logic [1:0] acc,
                            output int low_t, output int dn, output int er);
      int t_r, n, d0, e0, lo, hi;
      d0 = done_cnt;
      e0 = err_cnt;
      got = '0;
      low_t = -1;
      start_tx(d, t_r, acc);
      n = 0;
      while (clk_oe && n < 4000) begin @(negedge clk); n++; end
      if (!clk_oe) low_t = ticks - t_r;
      wait_ticks(FL + 3);
      for (int k = 0; k < 11; k++) begin
         got[k] = ps2_data;
         if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
         lo = FL + 2 + $urandom_range(0, 2);
         hi = FL + 2 + $urandom_range(0, 2);
         dev_clk = 1'b0;
         wait_ticks(lo);
         dev_clk = 1'b1;
         wait_ticks(hi);
         if (glitch && k < 10) begin
            if (k == 4) begin
               host.TX_DATA  = ~d;
               host.TX_START = 1'b1;
               @(negedge clk);
               host.TX_START = 1'b0;
            end
            dev_clk = 1'b0;
            wait_ticks($urandom_range(1, 2));
            dev_clk = 1'b1;
            wait_ticks(hi);
         end
      end
      dev_data = 1'b1;
      n = 0;
      while (host.BUSY && n < 4000) begin @(negedge clk); n++; end
      repeat (20) @(negedge clk);
      dn = done_cnt - d0;
      er = err_cnt - e0;
   endtask
   task automatic test_reset;
      n_checks++; if (clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", clk_oe); else n_pass++;
      n_checks++; if (data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", data_oe); else n_pass++;
      n_checks++; if (host.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", host.BUSY); else n_pass++;
      n_checks++; if (host.DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", host.DONE); else n_pass++;
      n_checks++; if (host.ERROR !== 1'b0) $display("FAIL reset_error: got %b want 0", host.ERROR); else n_pass++;
   endtask
   task automatic test_send(input logic [7:0] d, input string nm);
      logic [10:0] got, exp;
      logic [1:0]  acc;
      int          low_t, dn, er;
      exp = frame_of(d);
      run_frame(d, 1'b1, 1'b0, got, acc, low_t, dn, er);
      n_checks++; if (acc !== 2'b11) $display("FAIL %s_accept: clk_oe,busy got %b want 11", nm, acc); else n_pass++;
      n_checks++; if (low_t != IT + 1) $display("FAIL %s_clk_low: got %0d want %0d ticks", nm, low_t, IT + 1); else n_pass++;
      n_checks++; if (got !== exp) $display("FAIL %s_frame %h: got %b want %b", nm, d, got, exp); else n_pass++;
      n_checks++; if (got[9] !== exp[9]) $display("FAIL %s_parity %h: got %b want %b", nm, d, got[9], exp[9]); else n_pass++;
      n_checks++; if (dn != 1 || er != 0) $display("FAIL %s_result: done %0d error %0d want 1 0", nm, dn, er); else n_pass++;
      n_checks++; if (host.BUSY !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", nm, host.BUSY); else n_pass++;
   endtask
   task automatic test_parity;
      logic [7:0] fixed [3];
      fixed = '{8'hED, 8'hFF, 8'h00};
      foreach (fixed[i]) test_send(fixed[i], "parity");
      for (int i = 0; i < 4; i++) test_send(8'($urandom), "random");
   endtask
   task automatic test_nack;
      logic [10:0] got;
      logic [7:0]  d;
      logic [1:0]  acc;
      int          low_t, dn, er;
      d = 8'($urandom);
      run_frame(d, 1'b0, 1'b0, got, acc, low_t, dn, er);
      n_checks++; if (got !== frame_of(d)) $display("FAIL nack_frame: got %b want %b", got, frame_of(d)); else n_pass++;
      n_checks++; if (er != 1 || dn != 0) $display("FAIL nack_result: done %0d error %0d want 0 1", dn, er); else n_pass++;
      n_checks++; if (host.BUSY !== 1'b0) $display("FAIL nack_busy: got %b want 0", host.BUSY); else n_pass++;
   endtask
   task automatic test_timeout;
      logic [1:0] acc;
      int         t_r, t0, n, e0;
      e0 = err_cnt;
      t0 = -1;
      start_tx(8'hFF, t_r, acc);
      n = 0;
      while (clk_oe && n < 4000) begin @(negedge clk); n++; end
      if (!clk_oe) t0 = ticks;
      n = 0;
      while (!host.ERROR && n < 4000) begin @(negedge clk); n++; end
      n_checks++; if (ticks - t0 != TO || t0 < 0) $display("FAIL timeout_ticks: got %0d want %0d", ticks - t0, TO); else n_pass++;
      n_checks++; if ({clk_oe, data_oe, host.BUSY} !== 3'b000) $display("FAIL timeout_release: oe,oe,busy got %b want 000", {clk_oe, data_oe, host.BUSY}); else n_pass++;
      repeat (10) @(negedge clk);
      n_checks++; if (err_cnt - e0 != 1) $display("FAIL timeout_error_pulses: got %0d want 1", err_cnt - e0); else n_pass++;
   endtask
   task automatic test_glitch;
      logic [10:0] got;
      logic [7:0]  d;
      logic [1:0]  acc;
      int          low_t, dn, er, busy_cyc;
      d = 8'($urandom);
      run_frame(d, 1'b1, 1'b1, got, acc, low_t, dn, er);
      n_checks++; if (got !== frame_of(d)) $display("FAIL glitch_frame: got %b want %b", got, frame_of(d)); else n_pass++;
      n_checks++; if (dn != 1 || er != 0) $display("FAIL glitch_result: done %0d error %0d want 1 0", dn, er); else n_pass++;
      n_checks++; if (low_t != IT + 1) $display("FAIL glitch_clk_low: got %0d want %0d ticks", low_t, IT + 1); else n_pass++;
      busy_cyc = 0;
      repeat (50) begin @(negedge clk); if (host.BUSY || clk_oe) busy_cyc++; end
      n_checks++; if (busy_cyc != 0) $display("FAIL start_not_queued: busy cycles got %0d want 0", busy_cyc); else n_pass++;
   endtask
   task automatic test_reset_mid;
      logic [1:0] acc;
      int         t_r, n;
      start_tx(8'hA5, t_r, acc);
      n = 0;
      while (clk_oe && n < 4000) begin @(negedge clk); n++; end
      n_checks++; if (data_oe !== 1'b1) $display("FAIL send_start_bit: data_oe got %b want 1", data_oe); else n_pass++;
      nRESET = 1'b0;
      @(negedge clk);
      n_checks++; if ({clk_oe, data_oe, host.BUSY} !== 3'b000) $display("FAIL reset_mid: oe,oe,busy got %b want 000", {clk_oe, data_oe, host.BUSY}); else n_pass++;
      nRESET = 1'b1;
      repeat (5) @(negedge clk);
   endtask
   initial begin
      nRESET = 1'b0;
      host.TX_START = 1'b0;
      host.TX_DATA = 8'h00;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (4) @(negedge clk);
      test_reset;
      nRESET = 1'b1;
      repeat (2) @(negedge clk);
      test_send(8'hF4, "f4");
      test_parity;
      test_nack;
      test_timeout;
      test_glitch;
      test_reset_mid;
      n_checks++; if (bad_cnt != 0) $display("FAIL pulse_overlap: got %0d events want 0", bad_cnt); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
